// File: rtl/dcache_axi_pkg.sv
// Shared types and AXI constants for the D-cache AXI read side.
// line_align clears the byte offset within a cache line.
package dcache_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } rd_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  // line_bytes must be a power of two.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned line_bytes);
    return addr & ~(64'(line_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/dcache_axi_rd_ctrl.sv
// D-cache refill read controller: one INCR burst of LINE_BEATS beats per
// request, beats forwarded combinationally to the return buffer.
module dcache_axi_rd_ctrl
  import dcache_axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              refill_done,
  output logic              refill_err,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              d_arvalid,
  output logic              d_rvalid,
  output logic              d_rlast,
  output logic [DATA_W-1:0] d_rdata
);

  localparam int unsigned LINE_BYTES = LINE_BEATS * DATA_W / 8;
  localparam int          CNT_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_BEATS - 1);

  rd_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              rd_rdy_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              done_q;
  logic              refill_err_q;

  logic [ADDR_W-1:0] line_addr;
  logic              beat;
  logic              cnt_last;
  logic              final_beat;
  logic              beat_err;

  assign line_addr  = ADDR_W'(line_align(64'(rd_addr), LINE_BYTES));
  // rready_q is only ever high in R, so it also gates forwarding.
  assign beat       = rvalid & rready_q;
  assign cnt_last   = (cnt_q == LAST_CNT);
  assign final_beat = beat & (rlast | cnt_last);
  // rlast disagreeing with the beat count covers both early and missing rlast.
  assign beat_err   = beat & ((rresp != RESP_OKAY) | (rlast != cnt_last));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      araddr_q     <= '0;
      rd_rdy_q     <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      done_q       <= 1'b0;
      refill_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            araddr_q  <= line_addr;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_rdy_q  <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= R;
          end
        end
        R: begin
          if (beat) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (beat_err) err_q <= 1'b1;
          end
          if (final_beat) begin
            rready_q     <= 1'b0;
            done_q       <= 1'b1;
            refill_err_q <= err_q | beat_err;
            state_q      <= DONE;
          end
        end
        DONE: begin
          done_q       <= 1'b0;
          refill_err_q <= 1'b0;
          rd_rdy_q     <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_rdy      = rd_rdy_q;
  assign refill_done = done_q;
  assign refill_err  = refill_err_q;
  assign araddr      = araddr_q;
  assign arlen       = 8'(LINE_BEATS - 1);
  assign arsize      = (DATA_W == 32) ? SIZE_4B : 3'($clog2(DATA_W / 8));
  assign arburst     = BURST_INCR;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign d_arvalid   = arvalid_q;
  assign d_rvalid    = beat;
  assign d_rlast     = final_beat;
  assign d_rdata     = rdata;

endmodule

// File: tb/tb_dcache_axi_rd_ctrl.sv
// Randomized bench for dcache_axi_rd_ctrl: a transaction-level model predicts
// the aligned address, the forwarded beats, the final beat and the error flag.
module tb_dcache_axi_rd_ctrl;

  localparam int LINE_BEATS = 4;
  localparam int LAST       = LINE_BEATS - 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        refill_done;
  logic        refill_err;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        d_arvalid;
  logic        d_rvalid;
  logic        d_rlast;
  logic [31:0] d_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_axi_rd_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_BEATS(LINE_BEATS)) dut (
    .clk(clk), .rstn(rstn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .refill_done(refill_done), .refill_err(refill_err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .d_arvalid(d_arvalid), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_rdy", rd_rdy, 1);
    check("rst_arvalid", arvalid, 0);
    check("rst_d_arvalid", d_arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_done", refill_done, 0);
    check("rst_err", refill_err, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_d_rlast", d_rlast, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, LINE_BEATS - 1);
    check("rst_arsize", arsize, 2);
    check("rst_arburst", arburst, 1);
  endtask

  // rlast_pos >= LINE_BEATS means rlast never comes; bad_beat/abort_beat < 0 disable.
  task automatic run_txn(input logic [31:0] addr, input int ar_delay, input int gap_pct,
                         input int bad_beat, input int rlast_pos, input int abort_beat,
                         input logic [31:0] data_base);
    logic [31:0] exp_addr;
    int          fin;
    bit          exp_err;
    int          b;
    int          cyc;
    bit          v;

    exp_addr = addr & ~32'(LINE_BEATS * 4 - 1);
    fin      = (rlast_pos < LAST) ? rlast_pos : LAST;
    exp_err  = (bad_beat >= 0 && bad_beat <= fin) || (rlast_pos != LAST);

    @(negedge clk);
    rd_req = 1'b1; rd_addr = addr; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    #1;
    check("idle_rd_rdy", rd_rdy, 1);
    check("idle_arvalid", arvalid, 0);
    @(posedge clk);

    for (int i = 0; i <= ar_delay; i++) begin
      @(negedge clk);
      rd_req  = 1'($urandom);
      rd_addr = $urandom;
      arready = (i == ar_delay);
      rvalid  = 1'($urandom);
      rlast   = 1'($urandom);
      #1;
      check("ar_valid", arvalid, 1);
      check("ar_d_arvalid", d_arvalid, 1);
      check("ar_addr", araddr, exp_addr);
      check("ar_arlen", arlen, LINE_BEATS - 1);
      check("ar_rd_rdy", rd_rdy, 0);
      check("ar_rready", rready, 0);
      check("ar_no_fwd", d_rvalid, 0);
      @(posedge clk);
    end

    b = 0; cyc = 0;
    while (b <= fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      arready = 1'b0;
      rd_req  = 1'($urandom);
      v       = ($urandom_range(99) >= gap_pct);
      rvalid  = v;
      rdata   = v ? data_base + 32'(b) : $urandom;
      rresp   = (v && b == bad_beat) ? 2'b10 : (v ? 2'b00 : 2'($urandom));
      rlast   = v && (b == rlast_pos);
      #1;
      if (v && b == abort_beat) begin
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        rvalid = 1'b0; rd_req = 1'b0; rlast = 1'b0;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
          #1;
          check("abort_no_done", refill_done, 0);
          check("abort_rd_rdy", rd_rdy, 1);
          @(negedge clk);
        end
        return;
      end
      check("r_rready", rready, 1);
      check("r_d_rvalid", d_rvalid, v);
      check("r_d_rlast", d_rlast, v && (b == fin));
      if (v) check("r_d_rdata", d_rdata, data_base + 32'(b));
      check("r_no_done", refill_done, 0);
      @(posedge clk);
      if (v) b++;
    end
    check("r_beats", b, fin + 1);

    @(negedge clk);
    rd_req = 1'b0;
    rvalid = 1'($urandom);
    rlast  = 1'($urandom);
    #1;
    check("done_pulse", refill_done, 1);
    check("done_err", refill_err, exp_err);
    check("done_rready", rready, 0);
    check("done_no_fwd", d_rvalid, 0);
    check("done_rd_rdy", rd_rdy, 0);
    @(posedge clk);

    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("post_done", refill_done, 0);
    check("post_err", refill_err, 0);
    check("post_rd_rdy", rd_rdy, 1);
    check("post_no_fwd", d_rvalid, 0);
  endtask

  initial begin
    rstn = 1'b0; rd_req = 1'b0; rd_addr = '0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rstn = 1'b1; rvalid = 1'b0;

    run_txn(32'h1C00_0134, 0, 0, -1, LAST, -1, 32'h0000_00A0);
    run_txn($urandom, 5, 0, -1, LAST, -1, $urandom);
    run_txn($urandom, 1, 55, -1, LAST, -1, $urandom);
    run_txn($urandom, 0, 0, 1, LAST, -1, $urandom);
    run_txn($urandom, 0, 0, -1, LAST, -1, $urandom);
    run_txn($urandom, 0, 0, -1, 2, -1, $urandom);
    run_txn($urandom, 2, 20, -1, LINE_BEATS, -1, $urandom);
    run_txn($urandom, 0, 0, -1, LAST, 2, $urandom);
    run_txn($urandom, 1, 0, -1, LAST, -1, $urandom);

    for (int t = 0; t < 40; t++) begin
      int bad;
      int rl;
      bad = ($urandom_range(3) == 0) ? int'($urandom_range(LAST)) : -1;
      rl  = ($urandom_range(9) < 7) ? LAST : int'($urandom_range(LINE_BEATS));
      run_txn($urandom, int'($urandom_range(3)), int'($urandom_range(60)), bad, rl, -1, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_axi_rd_ctrl.md
# dcache_axi_rd_ctrl

Data-cache refill read controller on the AXI side of the D-cache. It accepts a line-refill request from the D-cache miss logic and issues one AXI4 INCR read burst of LINE_BEATS 32-bit beats. It forwards each returned beat to the return buffer (`d_arvalid` / `d_rvalid` / `d_rlast` / `d_rdata`), and reports completion and error status back to the cache.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, AXI data and beat width
- LINE_BEATS, 4, beats per cache line; must be a power of two; line size = LINE_BEATS*DATA_W/8 bytes

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- rd_req  in  1  refill request from the D-cache; sampled only while rd_rdy=1
- rd_addr  in  ADDR_W  miss address; any byte offset
- rd_rdy  out  1  controller idle, can accept rd_req
- refill_done  out  1  one-cycle pulse when the burst has completed
- refill_err  out  1  valid with refill_done: any non-OKAY rresp or rlast mismatch
- araddr  out  ADDR_W  line-aligned burst address
- arlen  out  8  constant LINE_BEATS-1
- arsize  out  3  constant log2(DATA_W/8) (3'b010)
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_W  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- d_arvalid  out  1  to return buffer; equals arvalid
- d_rvalid  out  1  to return buffer; equals rvalid & rready
- d_rlast  out  1  to return buffer; high on the beat counted as last
- d_rdata  out  DATA_W  to return buffer; equals rdata

## Operation
- FSM states: IDLE, AR, R, DONE. All state is reset to IDLE by rstn.
- IDLE:
  - rd_rdy=1.
  - On rd_req, latch araddr = rd_addr with its low log2(LINE_BYTES) bits cleared.
  - Clear the beat counter and error flag, then go to AR.
- AR:
  - arvalid=1 with araddr held stable.
  - On arready go to R. arvalid never drops before the handshake.
- R:
  - rready=1.
  - Each rvalid beat is forwarded combinationally to d_* and increments a log2(LINE_BEATS)-bit counter.
  - The final beat is the beat where rlast=1 or the counter equals LINE_BEATS-1, whichever comes first.
  - d_rlast is high on that final beat.
  - On the final beat go to DONE.
- Error flag is set (sticky until the next request) by any of:
  - rresp != 2'b00 on any beat;
  - rlast=1 with counter != LINE_BEATS-1 (early rlast);
  - counter == LINE_BEATS-1 with rlast=0 (missing rlast).
- DONE:
  - refill_done=1 for exactly one cycle, with refill_err equal to the error flag.
  - Next state is IDLE.
- Beats with rvalid outside state R are not accepted (rready=0) and are never forwarded.
- rd_req while rd_rdy=0 is ignored. The cache holds its request until it sees rd_rdy.

## Timing
- Reset values: rd_rdy=1, arvalid=0, rready=0, refill_done=0, refill_err=0, d_rvalid=0, d_rlast=0, araddr=0. Constant outputs arlen/arsize/arburst hold their constants.
- rd_req accepted in cycle N → arvalid=1 in cycle N+1.
- Zero-wait burst: AR handshake in N+1; beats in N+2..N+5; refill_done in N+6; rd_rdy=1 in N+7.
- Back-to-back: a request accepted in N+7 gets arvalid in N+8.
- d_rvalid/d_rlast/d_rdata are combinational from rvalid/rlast/rdata in state R, so the return buffer captures beat k on the same edge the AXI R handshake completes.
- Gaps in rvalid or delayed arready simply stall the FSM; there is no timeout.
- rstn asserted mid-operation: immediate return to IDLE, all outputs at their reset values, no refill_done. The interconnect must be reset alongside.

## Structure
- Shared package dcache_axi_pkg holds:
  - enum rd_state_t {IDLE, AR, R, DONE};
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, SIZE_4B=3'b010;
  - function line_align(addr).
- Single module; the beat counter and error flag are inline. No sub-module is needed.

## Test plan
- Request rd_addr=0x1C00_0134, arready=1, rvalid every cycle with data 0xA0..0xA3 and rlast on beat 3:
  - araddr=0x1C00_0130, arlen=3;
  - d_rvalid high for 4 cycles, d_rlast high on data 0xA3;
  - refill_done one cycle after the last beat, refill_err=0.
- arready held low 5 cycles: arvalid and araddr stay stable all 5 cycles; the handshake completes on cycle 6; rd_rdy=0 throughout.
- rvalid toggling 1,0,0,1,1,0,1: exactly 4 beats are forwarded, in order; refill_done only after the 4th beat.
- rresp=2'b10 on beat 1: all 4 beats still forwarded; refill_done with refill_err=1; the next request starts with refill_err=0.
- rlast on beat 2 (early): d_rlast on beat 2, refill_done next cycle, refill_err=1.
- rstn pulsed low during beat 2: outputs at reset values immediately; rd_rdy=1 after release; no refill_done. A new request then completes normally.
